// File: rtl/tpu_pkg.sv
// tpu_pkg: widths, FSM state type and tiling helper shared by
// the 4x4 systolic matmul accelerator (tpu_top, global_buffer).
package tpu_pkg;

  localparam int DATA_SIZE        = 8;
  localparam int WORD_SIZE        = 32;
  localparam int GBUFF_INDEX_SIZE = 8;
  localparam int GBUFF_ADDR_SIZE  = 32;
  localparam int ACC_SIZE         = 20;

  localparam int ARR       = 4;
  localparam int DRAIN_CYC = 7;
  localparam int WRITE_CYC = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RUN,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  typedef logic [DATA_SIZE-1:0]        elem_t;
  typedef logic [ACC_SIZE-1:0]         acc_t;
  typedef logic [GBUFF_INDEX_SIZE-1:0] idx_t;
  typedef logic [WORD_SIZE-1:0]        word_t;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] k;
    logic [3:0] n;
  } dims_t;

  function automatic logic [2:0] ceil4(input logic [3:0] x);
    return 3'((5'(x) + 5'd3) >> 2);
  endfunction

endpackage

// File: rtl/global_buffer.sv
// global_buffer: 256 x 32 single-port RAM, sync write, 1-cycle read.
// Ports: clk, we, addr, wdata -> rdata.
module global_buffer
  import tpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        we,
  input  logic [GBUFF_INDEX_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0]        wdata,
  output logic [WORD_SIZE-1:0]        rdata
);

  logic [WORD_SIZE-1:0] gbuff [0:(1<<GBUFF_INDEX_SIZE)-1];

  always_ff @(posedge clk) begin
    if (we)
      gbuff[addr] <= wdata;
    rdata <= gbuff[addr];
  end

endmodule

// File: rtl/tpu_top.sv
// tpu_top: C = A*B on a 4x4 output-stationary systolic array, tiled 4x4.
// Ports: clk, rst (sync, low), start, m/k/n dims -> done.
module tpu_top
  import tpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] m,
  input  logic [3:0] k,
  input  logic [3:0] n,
  output logic       done
);

  state_t state, state_nx;
  dims_t  dim;

  logic [3:0] cnt;
  logic [2:0] p_cnt, q_cnt;
  logic [2:0] p_num, q_num;
  logic       last_tile;
  logic [3:0] row;

  logic  acc_clr;
  logic  o_we;
  idx_t  a_addr, b_addr, o_addr;
  word_t a_rdata, b_rdata, o_rdata, o_wdata;
  logic  unused_out;

  logic  rd_vld;
  word_t a_gate, b_gate;
  elem_t sa [6];
  elem_t sb [6];
  elem_t a_in [ARR];
  elem_t b_in [ARR];

  elem_t a_reg [ARR][ARR-1];
  elem_t b_reg [ARR-1][ARR];
  acc_t  acc   [ARR][ARR];

  assign p_num = ceil4(dim.m);
  assign q_num = ceil4(dim.n);
  assign last_tile = (p_cnt == p_num - 3'd1) &&
                     (q_cnt == q_num - 3'd1);
  assign row = {p_cnt[1:0], cnt[1:0]};
  assign unused_out = ^o_rdata;

  global_buffer GBUFF_A (
    .clk   (clk),
    .we    (1'b0),
    .addr  (a_addr),
    .wdata ('0),
    .rdata (a_rdata)
  );

  global_buffer GBUFF_B (
    .clk   (clk),
    .we    (1'b0),
    .addr  (b_addr),
    .wdata ('0),
    .rdata (b_rdata)
  );

  global_buffer GBUFF_OUT (
    .clk   (clk),
    .we    (o_we),
    .addr  (o_addr),
    .wdata (o_wdata),
    .rdata (o_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start) state_nx = LOAD_RUN;
      LOAD_RUN:
        if (cnt == dim.k - 4'd1) state_nx = DRAIN;
      DRAIN:
        if (cnt == 4'(DRAIN_CYC - 1)) state_nx = WRITE;
      WRITE:
        if (cnt == 4'(WRITE_CYC - 1))
          state_nx = last_tile ? DONE : LOAD_RUN;
      DONE:
        state_nx = DONE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    done    = 1'b0;
    acc_clr = 1'b0;
    o_we    = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    o_addr  = '0;
    o_wdata = '0;
    unique case (state)
      IDLE:
        acc_clr = start;
      LOAD_RUN: begin
        a_addr = idx_t'(p_cnt) * idx_t'(dim.k) + idx_t'(cnt);
        b_addr = idx_t'(q_cnt) * idx_t'(dim.k) + idx_t'(cnt);
      end
      WRITE: begin
        o_we    = row < dim.m;
        o_addr  = idx_t'(row) * idx_t'(q_num) + idx_t'(q_cnt);
        acc_clr = cnt == 4'(WRITE_CYC - 1);
        // columns past n are padding and stored as zero
        for (int j = 0; j < ARR; j++)
          if ({q_cnt[1:0], 2'(j)} < dim.n)
            o_wdata[8*j +: 8] = acc[cnt[1:0]][j][7:0];
      end
      DONE:
        done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      p_cnt <= '0;
      q_cnt <= '0;
      dim   <= '0;
    end else begin
      cnt <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
      if (state == IDLE && start) begin
        dim   <= {m, k, n};
        p_cnt <= '0;
        q_cnt <= '0;
      end else if (state == WRITE &&
                   cnt == 4'(WRITE_CYC - 1)) begin
        if (q_cnt == q_num - 3'd1) begin
          q_cnt <= '0;
          p_cnt <= p_cnt + 3'd1;
        end else begin
          q_cnt <= q_cnt + 3'd1;
        end
      end
    end
  end

  // read data is only meaningful the cycle after a LOAD_RUN read;
  // gating keeps zeros in the array outside the k-step window
  always_ff @(posedge clk) begin
    if (!rst)
      rd_vld <= 1'b0;
    else
      rd_vld <= state == LOAD_RUN;
  end

  assign a_gate = rd_vld ? a_rdata : '0;
  assign b_gate = rd_vld ? b_rdata : '0;

  // lane i delayed by i cycles: lane1 sa[0], lane2 sa[1..2],
  // lane3 sa[3..5]
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) begin
        sa[i] <= '0;
        sb[i] <= '0;
      end
    end else begin
      sa[0] <= a_gate[15:8];
      sa[1] <= a_gate[23:16];
      sa[2] <= sa[1];
      sa[3] <= a_gate[31:24];
      sa[4] <= sa[3];
      sa[5] <= sa[4];
      sb[0] <= b_gate[15:8];
      sb[1] <= b_gate[23:16];
      sb[2] <= sb[1];
      sb[3] <= b_gate[31:24];
      sb[4] <= sb[3];
      sb[5] <= sb[4];
    end
  end

  always_comb begin
    a_in[0] = a_gate[7:0];
    a_in[1] = sa[0];
    a_in[2] = sa[2];
    a_in[3] = sa[5];
    b_in[0] = b_gate[7:0];
    b_in[1] = sb[0];
    b_in[2] = sb[2];
    b_in[3] = sb[5];
  end

  for (genvar i = 0; i < ARR; i++) begin : g_row
    for (genvar j = 0; j < ARR; j++) begin : g_col
      elem_t       a_l, b_t;
      logic [15:0] prod;

      if (j == 0) begin : g_al
        assign a_l = a_in[i];
      end else begin : g_ar
        assign a_l = a_reg[i][j-1];
      end

      if (i == 0) begin : g_bt
        assign b_t = b_in[j];
      end else begin : g_bb
        assign b_t = b_reg[i-1][j];
      end

      assign prod = {8'h00, a_l} * {8'h00, b_t};

      if (j < ARR - 1) begin : g_af
        always_ff @(posedge clk) begin
          if (!rst)
            a_reg[i][j] <= '0;
          else
            a_reg[i][j] <= a_l;
        end
      end

      if (i < ARR - 1) begin : g_bf
        always_ff @(posedge clk) begin
          if (!rst)
            b_reg[i][j] <= '0;
          else
            b_reg[i][j] <= b_t;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst || acc_clr)
          acc[i][j] <= '0;
        else
          acc[i][j] <= acc[i][j] + ACC_SIZE'(prod);
      end
    end
  end

endmodule

// File: tb/tb_tpu_top.sv
// tb_tpu_top: directed checks of tpu_top through buffer hierarchy.
// Preloads GBUFF_A/B, runs jobs, compares GBUFF_OUT and done.
module tb_tpu_top;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] m, k, n;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] SENT = 32'hDEADBEEF;

  logic [31:0] brow [4] = '{
    32'h03020100, 32'h07060504,
    32'h0B0A0908, 32'h0F0E0D0C
  };

  tpu_top dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .m     (m),
    .k     (k),
    .n     (n),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic clr_bufs();
    for (int i = 0; i < 256; i++) begin
      dut.GBUFF_A.gbuff[i]   <= 32'h0;
      dut.GBUFF_B.gbuff[i]   <= 32'h0;
      dut.GBUFF_OUT.gbuff[i] <= SENT;
    end
  endtask

  task automatic reset_dut();
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b1;
  endtask

  task automatic go(input int bound, input bit hold);
    int cyc;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (!hold) start = 1'b0;
    while (!done && cyc < bound + 8) begin
      @(negedge clk);
      cyc++;
    end
    check("done", {31'b0, done}, 32'd1);
    check("lat", {31'b0, (cyc - 1) <= bound}, 32'd1);
  endtask

  task automatic load3();
    clr_bufs();
    for (int w = 0; w < 3; w++) begin
      dut.GBUFF_A.gbuff[w]     <= 32'h04030201;
      dut.GBUFF_A.gbuff[w + 3] <= 32'h00000005;
    end
    for (int w = 0; w < 6; w++)
      dut.GBUFF_B.gbuff[w] <= 32'h01010101;
    for (int w = 6; w < 9; w++)
      dut.GBUFF_B.gbuff[w] <= 32'h00000001;
  endtask

  task automatic check3(input string pfx);
    logic [7:0]  v;
    logic [31:0] e;
    for (int r = 0; r < 5; r++)
      for (int q = 0; q < 3; q++) begin
        v = 8'(3 * (r + 1));
        e = (q < 2) ? {v, v, v, v} : {24'h0, v};
        check($sformatf("%s_w%0d", pfx, r * 3 + q),
              dut.GBUFF_OUT.gbuff[r * 3 + q], e);
      end
    for (int w = 15; w < 20; w++)
      check($sformatf("%s_untouched%0d", pfx, w),
            dut.GBUFF_OUT.gbuff[w], SENT);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    m = 4'd0;
    k = 4'd0;
    n = 4'd0;

    // identity times B
    clr_bufs();
    for (int kk = 0; kk < 4; kk++) begin
      dut.GBUFF_A.gbuff[kk] <= 32'h1 << (8 * kk);
      dut.GBUFF_B.gbuff[kk] <= brow[kk];
    end
    m = 4'd4; k = 4'd4; n = 4'd4;
    reset_dut();
    go(24, 1'b0);
    for (int r = 0; r < 4; r++)
      check($sformatf("id_w%0d", r), dut.GBUFF_OUT.gbuff[r], brow[r]);
    check("id_w4", dut.GBUFF_OUT.gbuff[4], SENT);

    // 1x1x1
    clr_bufs();
    dut.GBUFF_A.gbuff[0] <= 32'h3;
    dut.GBUFF_B.gbuff[0] <= 32'h5;
    m = 4'd1; k = 4'd1; n = 4'd1;
    reset_dut();
    go(17, 1'b0);
    check("one_w0", dut.GBUFF_OUT.gbuff[0], 32'h0000000F);
    for (int w = 1; w < 4; w++)
      check($sformatf("one_w%0d", w), dut.GBUFF_OUT.gbuff[w], SENT);
    repeat (10) @(negedge clk);
    check("one_hold", {31'b0, done}, 32'd1);

    // 5x3x9 multi-tile
    load3();
    m = 4'd5; k = 4'd3; n = 4'd9;
    reset_dut();
    go(94, 1'b0);
    check3("mt");

    // overflow wraps mod 256
    clr_bufs();
    for (int w = 0; w < 4; w++) begin
      dut.GBUFF_A.gbuff[w] <= 32'hFFFFFFFF;
      dut.GBUFF_B.gbuff[w] <= 32'hFFFFFFFF;
    end
    m = 4'd4; k = 4'd4; n = 4'd4;
    reset_dut();
    go(24, 1'b0);
    for (int w = 0; w < 4; w++)
      check($sformatf("ovf_w%0d", w), dut.GBUFF_OUT.gbuff[w], 32'h04040404);

    // reset during tile 1 LOAD_RUN, then rerun
    load3();
    m = 4'd5; k = 4'd3; n = 4'd9;
    reset_dut();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", {31'b0, done}, 32'd0);
    check("abort_w1", dut.GBUFF_OUT.gbuff[1], SENT);
    go(94, 1'b0);
    check3("rr");

    // start held high through and after the job
    clr_bufs();
    dut.GBUFF_A.gbuff[0] <= 32'h7;
    dut.GBUFF_B.gbuff[0] <= 32'h9;
    m = 4'd1; k = 4'd1; n = 4'd1;
    reset_dut();
    go(17, 1'b1);
    check("hold_w0", dut.GBUFF_OUT.gbuff[0], 32'h0000003F);
    dut.GBUFF_OUT.gbuff[0] <= SENT;
    repeat (20) @(negedge clk);
    check("hold_norew", dut.GBUFF_OUT.gbuff[0], SENT);
    check("hold_done", {31'b0, done}, 32'd1);
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
